// File: rtl/arbitro_mux_4_1.sv
// Round-robin arbiter owning the select lines of a shared 4:1 mux, with burst-capped grants.
// Define ARB_PRIORIDADE_FIXA_EN to switch the winner search to fixed priority (req[0] highest).
module arbitro_mux_4_1 #(
  parameter int W         = 1,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [3:0]   gnt,
  output logic         s1,
  output logic         s0,
  output logic [W-1:0] y,
  output logic         y_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  state_t     state;
  logic [1:0] last;
  logic [3:0] cnt;
  logic [1:0] sel;
  logic [1:0] owner;

  // Scan from lowest to highest priority so the highest-priority requester is assigned last.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] l);
    pick = l;
`ifdef ARB_PRIORIDADE_FIXA_EN
    for (int k = 3; k >= 0; k--) begin
      if (r[k]) pick = 2'(k);
    end
`else
    for (int k = 4; k >= 1; k--) begin
      logic [1:0] idx;
      idx = l + 2'(k);
      if (r[idx]) pick = idx;
    end
`endif
  endfunction

  assign owner = sel;
  assign s1    = sel[1];
  assign s0    = sel[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= 4'b0000;
      sel     <= 2'd0;
      last    <= 2'd3;
      cnt     <= 4'd0;
      y_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state   <= GRANT;
            sel     <= pick(req, last);
            last    <= pick(req, last);
            gnt     <= 4'b0001 << pick(req, last);
            cnt     <= 4'd1;
            y_valid <= 1'b1;
          end
        end
        GRANT: begin
          if (!req[owner]) begin
            // Release takes precedence over burst expiry; hand over without an idle cycle.
            if (|req) begin
              sel  <= pick(req, owner);
              last <= pick(req, owner);
              gnt  <= 4'b0001 << pick(req, owner);
              cnt  <= 4'd1;
            end else begin
              state   <= IDLE;
              gnt     <= 4'b0000;
              y_valid <= 1'b0;
            end
          end else if (cnt < MAX_B) begin
            cnt <= cnt + 4'd1;
          end else begin
            sel  <= pick(req, owner);
            last <= pick(req, owner);
            gnt  <= 4'b0001 << pick(req, owner);
            cnt  <= 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data path is purely combinational from the registered select; no source leaks when idle.
  always_comb begin
    y = '0;
    if (y_valid) begin
      case (sel)
        2'd0:    y = d0;
        2'd1:    y = d1;
        2'd2:    y = d2;
        default: y = d3;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_mux_4_1.sv
// Scoreboard bench for arbitro_mux_4_1: directed test-plan sequences followed by random traffic.
module tb_arbitro_mux_4_1;
  localparam int W  = 4;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = 4'b0000;
  logic [W-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [3:0]   gnt;
  logic         s1, s0, y_valid;
  logic [W-1:0] y;

  arbitro_mux_4_1 #(.W(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .gnt(gnt), .s1(s1), .s0(s0), .y(y), .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic         yv;
    logic [W-1:0] y;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   pushed = 0;
  int   popped = 0;
  bit   done = 0;
  bit   rand_d = 1;

  // Reference state: owner index or -1, plus the bookkeeping the rules describe.
  int m_owner = -1;
  int m_last  = 3;
  int m_cnt   = 0;
  int m_sel   = 0;

  function automatic int choose(input logic [3:0] r, input int after);
    int idx;
`ifdef ARB_PRIORIDADE_FIXA_EN
    for (int k = 0; k < 4; k++) if (r[k]) return k;
`else
    for (int k = 1; k <= 4; k++) begin
      idx = (after + k) % 4;
      if (r[idx]) return idx;
    end
`endif
    return -1;
  endfunction

  task automatic model_step(input logic r_rst, input logic [3:0] r);
    int w;
    if (r_rst) begin
      m_owner = -1; m_last = 3; m_cnt = 0; m_sel = 0;
    end else if (m_owner < 0 || !r[m_owner] || m_cnt >= MB) begin
      w = choose(r, (m_owner < 0) ? m_last : m_owner);
      if (w < 0) m_owner = -1;
      else begin
        m_owner = w; m_last = w; m_sel = w; m_cnt = 1;
      end
    end else begin
      m_cnt++;
    end
  endtask

  // Apply one cycle of inputs at the falling edge and record the response expected after the next rise.
  task automatic cyc(input logic r_rst, input logic [3:0] r);
    exp_t e;
    logic [W-1:0] dv[4];
    @(negedge clk);
    rst = r_rst;
    req = r;
    if (rand_d) begin
      d0 = W'($urandom); d1 = W'($urandom); d2 = W'($urandom); d3 = W'($urandom);
    end
    dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
    model_step(r_rst, r);
    e.gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    e.sel = 2'(m_sel);
    e.yv  = (m_owner >= 0);
    e.y   = (m_owner < 0) ? '0 : dv[m_owner];
    exp_q.push_back(e);
    pushed++;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req_v);
    tests++;
    if (act !== req_v) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req_v);
    end
  endtask

  // Monitor: compares every cycle for which an expectation has been queued.
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        popped++;
        check("gnt", 16'(gnt), 16'(e.gnt));
        check("sel", 16'({s1, s0}), 16'(e.sel));
        check("y_valid", 16'(y_valid), 16'(e.yv));
        check("y", 16'(y), 16'(e.y));
      end
    end
  end

  initial begin
    // Reset held with all requests active.
    cyc(1, 4'b1111);
    cyc(1, 4'b1111);
    // Saturation: first grant goes to 0, then rotates every MAX_BURST cycles.
    repeat (18) cyc(0, 4'b1111);
    repeat (2) cyc(0, 4'b0000);
    // Single requester with known data.
    rand_d = 0;
    d0 = '0; d1 = '0; d2 = W'(1); d3 = '0;
    repeat (3) cyc(0, 4'b0100);
    repeat (2) cyc(0, 4'b0000);
    rand_d = 1;
    // Handover from owner 0 to owner 3 without an idle cycle.
    cyc(0, 4'b0001);
    cyc(0, 4'b1001);
    repeat (2) cyc(0, 4'b1000);
    cyc(0, 4'b0000);
    // Solo burst expiry keeps the grant.
    repeat (10) cyc(0, 4'b0010);
    cyc(0, 4'b0000);
    // Reset mid-burst of owner 2.
    repeat (2) cyc(0, 4'b0100);
    cyc(1, 4'b0100);
    repeat (3) cyc(0, 4'b0100);
    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      r = 4'($urandom);
      if ($urandom_range(0, 3) == 0) r = 4'b1111;
      cyc(($urandom_range(0, 59) == 0), r);
    end
    cyc(0, 4'b0000);
    repeat (3) @(posedge clk);
    #2;
    done = 1;
    tests++;
    if (popped != pushed) begin
      fails++;
      $display("FAIL drain: checked %0d expected %0d", popped, pushed);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
